// File: rtl/adap_pred_chan_sched.sv
// Channel scheduler for the adaptive-predictor datapath: each frame sync walks channels 0..NCH-1 (read, start, wait, write back).
// Latency: fsync -> mem_rd next cycle -> dp_start LD_CYC+1 cycles later; per channel LD_CYC+3+run cycles.
// Backpressure: none; fsync during a frame is dropped and flagged, a hung datapath is cut off after TMO cycles.
module adap_pred_chan_sched #(
    parameter int NCH    = 32,
    parameter int CHW    = 5,
    parameter int LD_CYC = 2,
    parameter int TMO    = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           scan_in0,
    input  logic           scan_en,
    output logic           scan_out0,
    input  logic           en,
    input  logic           fsync,
    input  logic           err_clr,
    output logic [CHW-1:0] mem_addr,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           dp_start,
    input  logic           dp_done,
    output logic [CHW-1:0] ch_cur,
    output logic           busy,
    output logic           frame_done,
    output logic           overrun,
    output logic           timeout_err
);
    localparam int WDW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int LCW = (LD_CYC > 1) ? $clog2(LD_CYC) : 1;
    localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);
    localparam logic [LCW-1:0] LD_LAST = LCW'(LD_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LDW, S_START, S_RUN, S_WB} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CHW-1:0] ch;
    logic [WDW-1:0] wdog;
    logic [LCW-1:0] ld_cnt;
    logic           last_ch;
    logic           tmo_hit;
    logic           ch_adv;
    logic           frame_end;
    logic           wb_accept;
    logic           ovr_set;
    logic           unused_scan;

    assign unused_scan = scan_in0 ^ scan_en;
    assign scan_out0   = 1'b0;

    assign last_ch   = (ch == CH_LAST);
    assign tmo_hit   = (state == S_RUN) && !dp_done && (wdog == WD_LAST);
    assign ch_adv    = (state == S_WB) || tmo_hit;
    assign frame_end = ch_adv && last_ch;
    assign wb_accept = (state == S_WB) && last_ch && fsync && en;
    // The final write-back cycle counts as frame boundary: a sync there is not an overrun
    assign ovr_set   = fsync && (state != S_IDLE) && !((state == S_WB) && last_ch);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fsync && en) state_nxt = S_RD;
            S_RD:    state_nxt = S_LDW;
            S_LDW:   if (ld_cnt == LD_LAST) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN: begin
                if (dp_done)      state_nxt = S_WB;
                else if (tmo_hit) state_nxt = last_ch ? S_IDLE : S_RD;
            end
            S_WB:    state_nxt = (!last_ch || wb_accept) ? S_RD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = (state == S_RD);
        mem_wr   = (state == S_WB);
        dp_start = (state == S_START);
        busy     = (state != S_IDLE);
        mem_addr = ch;
        ch_cur   = ch;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch          <= '0;
            wdog        <= '0;
            ld_cnt      <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done  <= frame_end;
            overrun     <= ovr_set || (overrun && !err_clr);
            timeout_err <= tmo_hit || (timeout_err && !err_clr);
            if (ch_adv)
                ch <= last_ch ? '0 : ch + CHW'(1);
            if (state == S_RD)
                ld_cnt <= '0;
            else if ((state == S_LDW) && (ld_cnt != LD_LAST))
                ld_cnt <= ld_cnt + LCW'(1);
            if (state == S_START)
                wdog <= '0;
            else if ((state == S_RUN) && (wdog != WD_LAST))
                wdog <= wdog + WDW'(1);
        end
    end
endmodule
